tx_fifo: RTL and testbench
==========================

TX_FIFO -- requirements
Module: tx_fifo

Interface
REQ-001 The block SHALL take parameter FIFO_WIDTH, default 8, as the data width in bits.
REQ-002 The block SHALL take parameter FIFO_DEPTH, default 4, as the number of entries; 4 is the only supported value.
REQ-003 The block SHALL have port PCLK, input, width 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port CLEAR, input, width 1, the reset; it is synchronous and active-high.
REQ-005 The block SHALL have port PSEL, input, width 1, the APB peripheral select.
REQ-006 The block SHALL have port PWRITE, input, width 1, the APB write strobe.
REQ-007 The block SHALL have port PWDATA, input, width FIFO_WIDTH, the APB write data.
REQ-008 The block SHALL have port tx_pop, input, width 1, the transmit logic's request for the next byte.
REQ-009 The block SHALL have port TxData, output, width FIFO_WIDTH, the head-of-FIFO byte for the transmitter.
REQ-010 The block SHALL have port tx_valid, output, width 1, meaning TxData holds a valid byte.
REQ-011 The block SHALL have port SSPTXINTR, output, width 1, asserted while the FIFO is full.
REQ-012 The block SHALL have port fifo_empty, output, width 1, asserted while the FIFO is empty.
REQ-013 The block SHALL have port overflow, output, width 1, a sticky flag for a dropped APB write.
REQ-014 The block SHALL have port count, output, width 3, the current occupancy, 0 to 4.

Function
REQ-015 A push SHALL occur when PSEL=1, PWRITE=1 and either count<4 or a pop occurs in the same cycle; PWDATA is stored at wr_ptr and wr_ptr advances by 1.
REQ-016 A pop SHALL occur when tx_pop=1 and count>0; rd_ptr advances by 1.
REQ-017 wr_ptr and rd_ptr SHALL each be 2 bits wide and wrap from 3 to 0 with no special handling.
REQ-018 count SHALL update as follows: push only, +1; pop only, -1; push and pop together, unchanged; neither, unchanged.
REQ-019 When the FIFO is empty and a push and tx_pop occur together, the push SHALL be accepted, tx_pop ignored, and count goes to 1.
REQ-020 When the FIFO is full and a push and a pop occur together, both SHALL complete and count stays 4.
REQ-021 A push attempt with count=4 and no pop SHALL be dropped with storage unchanged, and overflow SHALL be set to 1 on the next edge.
REQ-022 overflow SHALL hold at 1 until CLEAR.
REQ-023 tx_pop with count=0 SHALL be a no-op: no pointer or count change, and no error flag.
REQ-024 TxData SHALL be combinational show-ahead: fifo[rd_ptr] when count>0, else all zeros.
REQ-025 tx_valid SHALL equal (count!=0).
REQ-026 A pushed byte SHALL appear on TxData with tx_valid=1 in the cycle after the push edge if the FIFO was empty (one-cycle latency).
REQ-027 SSPTXINTR SHALL equal (count==4), and fifo_empty SHALL equal (count==0); both are combinational from count.
REQ-028 APB reads (PSEL=1, PWRITE=0) SHALL be ignored by this block.
REQ-029 Byte order SHALL be strict FIFO: bytes leave on TxData in push order.

Reset
REQ-030 When CLEAR=1 at a rising PCLK edge, the block SHALL set wr_ptr=0, rd_ptr=0, count=0 and overflow=0.
REQ-031 Storage contents SHALL NOT be required to clear.
REQ-032 CLEAR SHALL take priority over any push or pop in the same cycle; that push or pop is discarded.
REQ-033 From the cycle after reset, outputs SHALL read TxData=0, tx_valid=0, SSPTXINTR=0, fifo_empty=1, overflow=0, count=0.
REQ-034 A reset asserted mid-operation with a partly full FIFO SHALL discard all queued bytes; the next push is read out first.

Verification
REQ-035 The bench SHALL cover single push/pop: after CLEAR, push 8'hA5, then hold tx_pop=0. Required: next cycle TxData=8'hA5, tx_valid=1, count=1. After tx_pop=1 for one cycle: count=0, TxData=0, fifo_empty=1.
REQ-036 The bench SHALL cover fill and overflow: push 11,22,33,44, then push 55 with tx_pop=0. Required: SSPTXINTR=1, count=4, overflow=1. Popping four times then yields 11,22,33,44; 55 never appears.
REQ-037 The bench SHALL cover simultaneous push/pop when full: at count=4 with head 11, push 66 and tx_pop=1 together. Required: count=4, SSPTXINTR=1, overflow stays 0, and the next head is 22. The byte 66 emerges fifth.
REQ-038 The bench SHALL cover simultaneous push/pop when empty: at count=0, push 77 and tx_pop=1 together. Required: count=1, TxData=77, tx_valid=1.
REQ-039 The bench SHALL cover pointer wrap: run 10 push-then-pop pairs of bytes 0x01..0x0A. Required: each byte is read out in order, and count alternates 1/0 throughout.
REQ-040 The bench SHALL cover reset mid-operation: with count=3 and overflow=1, assert CLEAR in the same cycle as a push of 99. Required: next cycle count=0, fifo_empty=1, overflow=0, TxData=0; 99 is not stored.

Source files
------------

// File: rtl/tx_fifo.sv
// tx_fifo: 4-entry APB-fed transmit FIFO with a show-ahead head byte and a sticky overflow flag.
module tx_fifo #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  PCLK,
  input  logic                  CLEAR,
  input  logic                  PSEL,
  input  logic                  PWRITE,
  input  logic [FIFO_WIDTH-1:0] PWDATA,
  input  logic                  tx_pop,
  output logic [FIFO_WIDTH-1:0] TxData,
  output logic                  tx_valid,
  output logic                  SSPTXINTR,
  output logic                  fifo_empty,
  output logic                  overflow,
  output logic [2:0]            count
);
  localparam logic [2:0] FULL = 3'(FIFO_DEPTH);
  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [1:0] wr_ptr, rd_ptr;
  logic wr, push, pop;
  // a full FIFO still accepts a write when the head leaves in the same cycle
  always_comb begin
    wr = PSEL & PWRITE;
    pop = tx_pop & (count != 3'd0);
    push = wr & ((count != FULL) | pop);
  end
  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count <= 3'd0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= push ? wr_ptr + 2'd1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 2'd1 : rd_ptr;
      count <= count + 3'(push) - 3'(pop);
      overflow <= overflow | (wr & ~push);
    end
  end
  always_ff @(posedge PCLK) begin
    if (!CLEAR && push) mem[wr_ptr] <= PWDATA;
  end
  assign TxData = (count != 3'd0) ? mem[rd_ptr] : '0;
  assign tx_valid = count != 3'd0;
  assign SSPTXINTR = count == FULL;
  assign fifo_empty = count == 3'd0;
endmodule

// File: tb/tb_tx_fifo.sv
// tb_tx_fifo: directed scenarios plus random traffic checked against a queue-based reference model.
module tb_tx_fifo;
  logic PCLK = 1'b0;
  logic CLEAR = 1'b0, PSEL = 1'b0, PWRITE = 1'b0, tx_pop = 1'b0;
  logic [7:0] PWDATA = 8'd0;
  logic [7:0] TxData;
  logic tx_valid, SSPTXINTR, fifo_empty, overflow;
  logic [2:0] count;
  int checks = 0, failures = 0;
  logic [7:0] q[$];
  logic ovf = 1'b0;

  tx_fifo #(.FIFO_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .PCLK(PCLK), .CLEAR(CLEAR), .PSEL(PSEL), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .tx_pop(tx_pop), .TxData(TxData), .tx_valid(tx_valid), .SSPTXINTR(SSPTXINTR),
    .fifo_empty(fifo_empty), .overflow(overflow), .count(count)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock of stimulus; the model follows the queue semantics, then all outputs are compared
  task automatic step(input logic clr, input logic sel, input logic wrt, input logic [7:0] d, input logic pp);
    bit can_pop, accept;
    CLEAR = clr; PSEL = sel; PWRITE = wrt; PWDATA = d; tx_pop = pp;
    @(posedge PCLK);
    if (clr) begin
      q.delete();
      ovf = 1'b0;
    end else begin
      can_pop = pp && q.size() > 0;
      accept = sel && wrt && (q.size() < 4 || can_pop);
      if (sel && wrt && !accept) ovf = 1'b1;
      if (can_pop) void'(q.pop_front());
      if (accept) q.push_back(d);
    end
    #1;
    CLEAR = 1'b0; PSEL = 1'b0; PWRITE = 1'b0; tx_pop = 1'b0;
    check("m_count", 32'(count), 32'(q.size()));
    check("m_txdata", 32'(TxData), q.size() > 0 ? 32'(q[0]) : 32'd0);
    check("m_valid", 32'(tx_valid), 32'(q.size() > 0));
    check("m_full", 32'(SSPTXINTR), 32'(q.size() == 4));
    check("m_empty", 32'(fifo_empty), 32'(q.size() == 0));
    check("m_ovf", 32'(overflow), 32'(ovf));
  endtask

  task automatic push(input logic [7:0] d);
    step(1'b0, 1'b1, 1'b1, d, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
  endtask

  task automatic clear();
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    logic [7:0] heads [4];
    clear();
    check("rst_txdata", 32'(TxData), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    // single push/pop
    push(8'hA5);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    check("single_data", 32'(TxData), 32'hA5);
    check("single_valid", 32'(tx_valid), 32'd1);
    check("single_count", 32'(count), 32'd1);
    pop();
    check("single_pop_count", 32'(count), 32'd0);
    check("single_pop_data", 32'(TxData), 32'd0);
    check("single_pop_empty", 32'(fifo_empty), 32'd1);
    // fill and overflow
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    push(8'h55);
    check("ovf_full", 32'(SSPTXINTR), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    heads = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      check("ovf_order", 32'(TxData), 32'(heads[i]));
      pop();
    end
    check("ovf_drained", 32'(count), 32'd0);
    // simultaneous push/pop when full
    clear();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    step(1'b0, 1'b1, 1'b1, 8'h66, 1'b1);
    check("full_pp_count", 32'(count), 32'd4);
    check("full_pp_intr", 32'(SSPTXINTR), 32'd1);
    check("full_pp_ovf", 32'(overflow), 32'd0);
    check("full_pp_head", 32'(TxData), 32'h22);
    pop(); pop(); pop();
    check("full_pp_fifth", 32'(TxData), 32'h66);
    pop();
    // simultaneous push/pop when empty
    step(1'b0, 1'b1, 1'b1, 8'h77, 1'b1);
    check("empty_pp_count", 32'(count), 32'd1);
    check("empty_pp_data", 32'(TxData), 32'h77);
    check("empty_pp_valid", 32'(tx_valid), 32'd1);
    pop();
    // pointer wrap
    for (int i = 1; i <= 10; i++) begin
      push(8'(i));
      check("wrap_count1", 32'(count), 32'd1);
      check("wrap_data", 32'(TxData), 32'(i));
      pop();
      check("wrap_count0", 32'(count), 32'd0);
    end
    // reset mid-operation
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4); push(8'hA5);
    pop();
    check("mid_pre_count", 32'(count), 32'd3);
    check("mid_pre_ovf", 32'(overflow), 32'd1);
    step(1'b1, 1'b1, 1'b1, 8'h99, 1'b0);
    check("mid_count", 32'(count), 32'd0);
    check("mid_empty", 32'(fifo_empty), 32'd1);
    check("mid_ovf", 32'(overflow), 32'd0);
    check("mid_data", 32'(TxData), 32'd0);
    push(8'h12);
    check("mid_next", 32'(TxData), 32'h12);
    check("mid_next_count", 32'(count), 32'd1);
    // APB read ignored
    step(1'b0, 1'b1, 1'b0, 8'hEE, 1'b0);
    check("read_ignored", 32'(count), 32'd1);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(99) == 0, 1'($urandom), $urandom_range(3) != 0, 8'($urandom), 1'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
